inst_cache: RTL and testbench
=============================

INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 The block SHALL use reset RESET, synchronous, active-high, and clock CLK.
REQ-002 Ports SHALL be:
  CLK  in  1  clock
  RESET  in  1  synchronous active-high reset
  pc_addr  in  32  fetch address from the PC stage (byte address, bits [1:0] ignored)
  pc_valid  in  1  fetch request this cycle
  flush  in  1  invalidate all lines (fence.i)
  instr  out  32  instruction word for pc_addr
  stall  out  1  fetch must hold PC and the IF/DE register
  mem_rd  out  1  word read request to backing instruction memory
  mem_addr  out  32  word-aligned read address
  mem_ack  in  1  backing memory returns data this cycle
  mem_rdata  in  32  returned word, valid when mem_ack=1
  miss_cnt  out  16  saturating miss counter

Function
REQ-003 Organisation SHALL be direct-mapped, 16 lines x 4 words; tag=pc_addr[31:8], index=pc_addr[7:4], word=pc_addr[3:2].
REQ-004 hit SHALL be combinational: state==IDLE & valid[index] & tag match.
REQ-005 On hit, instr SHALL equal the stored word in the same cycle (zero-latency, same as the combinational instruction memory it replaces), and stall=0.
REQ-006 stall SHALL be 1 whenever pc_valid=1 & !hit, or state!=IDLE; instr is don't-care while stall=1.
REQ-007 FSM states SHALL be IDLE, FILL, COMMIT.
REQ-008 IDLE -> FILL when pc_valid & !hit & !flush; latch line base {pc_addr[31:4],4'b0}, clear 2-bit word counter, increment miss_cnt (saturate at 0xFFFF).
REQ-009 In FILL, mem_rd=1 and mem_addr=base+4*counter; on mem_ack write mem_rdata into data[index][counter] and increment counter; mem_rd SHALL stay high with stable mem_addr until mem_ack.
REQ-010 FILL -> COMMIT on mem_ack with counter==3; words SHALL be requested in order 0,1,2,3 regardless of the missing word.
REQ-011 COMMIT SHALL write tag and set valid[index] (unless discard set), then -> IDLE; mem_rd=0 in COMMIT and IDLE.
REQ-012 The retried fetch SHALL hit the cycle after COMMIT; miss penalty = 4 acked reads + 2 cycles.
REQ-013 mem_ack outside FILL SHALL be ignored.
REQ-014 flush in IDLE SHALL clear all valid bits at the clock edge; simultaneous flush and miss: flush wins, no fill starts, stall=1 that cycle.
REQ-015 flush in FILL or COMMIT SHALL clear all valid bits and set discard; the fill completes but the line is not validated; discard clears on return to IDLE.
REQ-016 pc_addr changes during FILL SHALL NOT alter the latched base or index.
REQ-017 Conflict miss SHALL overwrite the resident line (no write-back; read-only cache).

Reset
REQ-018 RESET SHALL set state=IDLE, all valid=0, counter=0, discard=0, miss_cnt=0, mem_rd=0, mem_addr=0; stall=pc_valid after reset.
REQ-019 RESET mid-FILL SHALL abandon the fill; mem_rd SHALL be 0 the cycle after the reset edge; late mem_ack ignored.
REQ-020 Data and tag arrays need not be reset.

Structure
REQ-021 A shared package otter_cache_pkg SHALL hold LINES=16, WORDS=4, TAG_W=24, IDX_W=4, OFF_W=2 and the state enum.
REQ-022 Data/tag/valid storage SHALL be one sub-module icache_array (combinational read, synchronous write, synchronous valid clear); FSM and counters stay in inst_cache.

Verification
REQ-023 Cold miss pc=0x00000008, mem_ack 1 cycle after each mem_rd: mem_addr 0x0,0x4,0x8,0xC in order; stall high throughout; next cycle instr=word@0x8, stall=0, miss_cnt=1.
REQ-024 Sequential pc 0x0..0xC after fill: 4 consecutive hits, stall=0, mem_rd=0.
REQ-025 Conflict: fill 0x000, then pc=0x100 (same index 0): miss, refill 0x100-0x10C; then pc=0x000 misses again; miss_cnt=3.
REQ-026 Memory latency 3 cycles per word: mem_addr stable and mem_rd high until each ack; total stall = 4x4+2 cycles.
REQ-027 flush asserted during FILL word 2: fill completes, then same pc misses again (line not valid).
REQ-028 RESET during FILL word 1, then stray mem_ack: state IDLE, mem_rd=0, miss_cnt=0, next fetch of same pc misses.

Source files
------------

// File: rtl/otter_cache_pkg.sv
// Shared parameters, FSM state type and address-field helpers for the
// instruction cache.
package otter_cache_pkg;

  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam int TAG_W = 24;
  localparam int IDX_W = 4;
  localparam int OFF_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:32-TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return a[IDX_W+OFF_W+1:OFF_W+2];
  endfunction

  function automatic logic [OFF_W-1:0] addr_word(input logic [31:0] a);
    return a[OFF_W+1:2];
  endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-side and backing-memory signals of the instruction cache.
// slave = the cache itself, master = the core/memory environment.
interface inst_cache_if;
  logic [31:0] pc_addr;
  logic        pc_valid;
  logic        flush;
  logic [31:0] instr;
  logic        stall;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] miss_cnt;

  modport slave (
    input  pc_addr, pc_valid, flush, mem_ack, mem_rdata,
    output instr, stall, mem_rd, mem_addr, miss_cnt
  );

  modport master (
    output pc_addr, pc_valid, flush, mem_ack, mem_rdata,
    input  instr, stall, mem_rd, mem_addr, miss_cnt
  );
endinterface

// File: rtl/icache_array.sv
// Data, tag and valid storage: combinational read, synchronous write,
// synchronous valid clear (clear beats set).
module icache_array
  import otter_cache_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_word,
  output logic [31:0]      rd_data,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [OFF_W-1:0] wr_word,
  input  logic [31:0]      wr_data,
  input  logic             commit_en,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic             set_valid,
  input  logic             valid_clr
);

  logic [31:0]      data_q [LINES][WORDS];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q;

  always_ff @(posedge CLK) begin
    if (wr_en) data_q[wr_idx][wr_word] <= wr_data;
    if (commit_en) tag_q[wr_idx] <= commit_tag;
  end

  always_ff @(posedge CLK) begin
    if (RESET || valid_clr) valid_q <= '0;
    else if (commit_en && set_valid) valid_q[wr_idx] <= 1'b1;
  end

  assign rd_data  = data_q[rd_idx][rd_word];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped 16x4-word read-only instruction cache with zero-latency hit
// and an in-order line refill FSM.
module inst_cache
  import otter_cache_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  inst_cache_if.slave   bus
);

  state_t              state;
  logic [31:OFF_W+2]   line_q;
  logic [OFF_W-1:0]    cnt;
  logic [OFF_W-1:0]    cnt_nxt;
  logic                discard;
  logic [15:0]         miss_q;
  logic                mem_rd_q;
  logic [31:0]         mem_addr_q;

  logic [31:0]         rd_data;
  logic [TAG_W-1:0]    rd_tag;
  logic                rd_valid;
  logic                hit;
  logic                fill_wr;
  logic                unused_pc_lsb;

  assign unused_pc_lsb = ^bus.pc_addr[1:0];
  assign cnt_nxt = cnt + 2'd1;

  icache_array u_array (
    .CLK        (CLK),
    .RESET      (RESET),
    .rd_idx     (addr_idx(bus.pc_addr)),
    .rd_word    (addr_word(bus.pc_addr)),
    .rd_data    (rd_data),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .wr_en      (fill_wr),
    .wr_idx     (line_q[IDX_W+OFF_W+1:OFF_W+2]),
    .wr_word    (cnt),
    .wr_data    (bus.mem_rdata),
    .commit_en  (state == COMMIT),
    .commit_tag (line_q[31:32-TAG_W]),
    .set_valid  (!discard),
    .valid_clr  (bus.flush)
  );

  assign hit     = (state == IDLE) && rd_valid && (rd_tag == addr_tag(bus.pc_addr));
  assign fill_wr = (state == FILL) && bus.mem_ack;

  assign bus.instr    = rd_data;
  assign bus.stall    = (bus.pc_valid && !hit) || (state != IDLE);
  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.miss_cnt = miss_q;

  // mem_rd/mem_addr are registered so the bus request is stable for the
  // whole wait on each word; a flush mid-fill only suppresses validation.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      line_q     <= '0;
      cnt        <= '0;
      discard    <= 1'b0;
      miss_q     <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.pc_valid && !hit && !bus.flush) begin
            state      <= FILL;
            line_q     <= bus.pc_addr[31:OFF_W+2];
            cnt        <= '0;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= {bus.pc_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
            if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
          end
        end
        FILL: begin
          if (bus.flush) discard <= 1'b1;
          if (bus.mem_ack) begin
            cnt <= cnt_nxt;
            if (cnt == OFF_W'(WORDS-1)) begin
              state    <= COMMIT;
              mem_rd_q <= 1'b0;
            end else begin
              mem_addr_q <= {line_q, cnt_nxt, 2'b00};
            end
          end
        end
        COMMIT: begin
          state   <= IDLE;
          discard <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench: fetch-level reference model of a direct-mapped cache,
// directed corner cases, then randomized fetch/flush traffic.
module tb_inst_cache;
  import otter_cache_pkg::*;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  inst_cache_if bus ();
  inst_cache dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int mem_lat = 1;

  bit          model_valid [16];
  logic [23:0] model_tag   [16];
  int          model_miss;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return model_valid[pc[7:4]] && (model_tag[pc[7:4]] == pc[31:8]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_valid[i] = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    model_miss = 0;
  endtask

  // Holds pc_valid until the fetch completes; flush_word >= 0 pulses flush
  // while that word of the first fill is outstanding.
  task automatic fetch(input logic [31:0] pc, input int flush_word);
    int stalls = 0;
    int acks = 0;
    int wcnt = 0;
    int fills;
    int budget;
    bit flushed = 1'b0;
    logic [31:0] base;
    base = {pc[31:4], 4'b0000};
    fills = model_hit(pc) ? 0 : ((flush_word >= 0) ? 2 : 1);
    budget = 2 * (4 * (mem_lat + 1) + 2) + 4;
    bus.pc_addr  = pc;
    bus.pc_valid = 1'b1;
    forever begin
      bus.mem_ack = 1'b0;
      bus.flush   = 1'b0;
      if (bus.mem_rd) begin
        if (!flushed && flush_word >= 0 && acks == flush_word) begin
          bus.flush = 1'b1;
          flushed = 1'b1;
        end
        if (wcnt == mem_lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_word(bus.mem_addr);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      #1;
      if (!bus.stall) break;
      if (bus.mem_ack) begin
        check("fill_addr", bus.mem_addr, base + 32'(4 * (acks % 4)));
        acks++;
      end
      stalls++;
      if (stalls > budget) begin
        check("fetch_timeout", 32'(stalls), 32'(budget));
        break;
      end
      @(posedge CLK); #1;
    end
    bus.mem_ack = 1'b0;
    bus.flush   = 1'b0;
    check("stall_cycles", 32'(stalls), 32'(fills * (4 * (mem_lat + 1) + 2)));
    check("instr", bus.instr, mem_word({pc[31:2], 2'b00}));
    check("mem_rd_idle", 32'(bus.mem_rd), 32'd0);
    if (fills > 0) begin
      if (flush_word >= 0) model_clear();
      model_valid[pc[7:4]] = 1'b1;
      model_tag[pc[7:4]]   = pc[31:8];
      model_miss += fills;
    end
    check("miss_cnt", 32'(bus.miss_cnt), 32'(model_miss));
    @(posedge CLK); #1;
    bus.pc_valid = 1'b0;
  endtask

  task automatic do_flush();
    bus.pc_valid = 1'b0;
    bus.flush    = 1'b1;
    @(posedge CLK); #1;
    bus.flush = 1'b0;
    model_clear();
  endtask

  task automatic flush_with_miss(input logic [31:0] pc);
    bus.pc_addr  = pc;
    bus.pc_valid = 1'b1;
    bus.flush    = 1'b1;
    #1;
    check("flush_miss_stall", 32'(bus.stall), 32'd1);
    @(posedge CLK); #1;
    bus.flush    = 1'b0;
    bus.pc_valid = 1'b0;
    #1;
    check("flush_miss_no_fill", 32'(bus.mem_rd), 32'd0);
    check("flush_miss_cnt", 32'(bus.miss_cnt), 32'(model_miss));
    model_clear();
    @(posedge CLK); #1;
  endtask

  task automatic reset_mid_fill(input logic [31:0] pc);
    int acks = 0;
    int wcnt = 0;
    int cyc = 0;
    bus.pc_addr  = pc;
    bus.pc_valid = 1'b1;
    while (!(acks == 1 && bus.mem_rd) && cyc < 40) begin
      bus.mem_ack = 1'b0;
      if (bus.mem_rd) begin
        if (wcnt == mem_lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_word(bus.mem_addr);
          wcnt = 0;
          acks++;
        end else begin
          wcnt++;
        end
      end
      @(posedge CLK); #1;
      cyc++;
    end
    check("rst_reach_word1", 32'(acks), 32'd1);
    bus.mem_ack  = 1'b0;
    bus.pc_valid = 1'b0;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    #1;
    check("rst_fill_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst_fill_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    check("rst_fill_mem_addr", bus.mem_addr, 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    @(posedge CLK); #1;
    bus.mem_ack = 1'b0;
    #1;
    check("stray_ack_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("stray_ack_idle", 32'(bus.stall), 32'd0);
    check("stray_ack_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    model_reset();
    @(posedge CLK); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    int r;
    bus.pc_addr   = '0;
    bus.pc_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    model_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    check("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_miss_cnt", 32'(bus.miss_cnt), 32'd0);
    check("rst_stall_idle", 32'(bus.stall), 32'd0);
    bus.pc_addr  = 32'h0000_0008;
    bus.pc_valid = 1'b1;
    #1;
    check("rst_stall_pcvalid", 32'(bus.stall), 32'd1);
    bus.pc_valid = 1'b0;
    @(posedge CLK); #1;

    mem_lat = 1;
    fetch(32'h0000_0008, -1);
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), -1);

    fetch(32'h0000_0100, -1);
    fetch(32'h0000_0000, -1);
    check("conflict_miss_cnt", 32'(bus.miss_cnt), 32'd3);

    mem_lat = 3;
    fetch(32'h0000_0234, -1);

    mem_lat = 1;
    fetch(32'h0000_0350, 2);
    do_flush();
    fetch(32'h0000_0350, -1);

    flush_with_miss(32'hABC0_0040);
    fetch(32'hABC0_0040, -1);

    reset_mid_fill(32'h0000_0564);
    fetch(32'h0000_0564, -1);

    for (int n = 0; n < 80; n++) begin
      mem_lat = $urandom_range(0, 3);
      r = $urandom_range(0, 15);
      pc = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 15)) << 4)
           | 32'($urandom_range(0, 15));
      if (r == 0) do_flush();
      else fetch(pc, (r == 1) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
